// File: rtl/led_sequencer.sv
// LED pattern sequencer driven by the half-period timer's square wave.
// Every level change of tick_in advances the selected pattern by one step.
module led_sequencer #(
    parameter int LEDS       = 6,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic            clk_in,
    input  logic            reset,
    input  logic            tick_in,
    input  logic [1:0]      mode,
    input  logic            pause,
    output logic [LEDS-1:0] led
);

    localparam int PW = $clog2(LEDS);

    localparam logic [LEDS-1:0] MASK    = {LEDS{ACTIVE_LOW}};
    localparam logic [LEDS-1:0] ONE     = LEDS'(1);
    localparam logic [PW-1:0]   POS_TOP = PW'(LEDS - 1);
    localparam logic [PW-1:0]   POS_ONE = PW'(1);

    typedef enum logic [1:0] {
        M_COUNT  = 2'd0,
        M_WALK   = 2'd1,
        M_BOUNCE = 2'd2,
        M_BLINK  = 2'd3
    } mode_e;

    logic            tick_q, tick_d;
    mode_e           mode_q, mode_d;
    logic [LEDS-1:0] pat_q, pat_d;
    logic [PW-1:0]   pos_q, pos_d;
    logic            dir_q, dir_d;
    logic [LEDS-1:0] led_q, led_d;

    mode_e mode_sel;
    logic  step;

    assign mode_sel = mode_e'(mode);
    assign step     = tick_in ^ tick_q;

    always_comb begin
        tick_d = tick_in;
        mode_d = mode_q;
        pat_d  = pat_q;
        pos_d  = pos_q;
        dir_d  = dir_q;
        led_d  = pat_q ^ MASK;

        // A mode change wins over a coincident step, even while paused.
        if (mode_sel != mode_q) begin
            mode_d = mode_sel;
            pos_d  = '0;
            dir_d  = 1'b0;
            unique case (mode_sel)
                M_COUNT,
                M_BLINK:  pat_d = '0;
                M_WALK,
                M_BOUNCE: pat_d = ONE;
            endcase
        end else if (step && !pause) begin
            unique case (mode_q)
                M_COUNT: pat_d = pat_q + ONE;
                M_WALK:  pat_d = {pat_q[LEDS-2:0], pat_q[LEDS-1]};
                M_BOUNCE: begin
                    // Reverse on the end LED itself, so neither end dwells.
                    if (!dir_q) begin
                        if (pos_q == POS_TOP) begin
                            dir_d = 1'b1;
                            pos_d = POS_TOP - POS_ONE;
                        end else begin
                            pos_d = pos_q + POS_ONE;
                        end
                    end else begin
                        if (pos_q == '0) begin
                            dir_d = 1'b0;
                            pos_d = POS_ONE;
                        end else begin
                            pos_d = pos_q - POS_ONE;
                        end
                    end
                    pat_d = ONE << pos_d;
                end
                M_BLINK: pat_d = ~pat_q;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            tick_q <= 1'b0;
            mode_q <= M_COUNT;
            pat_q  <= '0;
            pos_q  <= '0;
            dir_q  <= 1'b0;
            led_q  <= MASK;
        end else begin
            tick_q <= tick_d;
            mode_q <= mode_d;
            pat_q  <= pat_d;
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            led_q  <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer: expected LED words are queued with
// the cycle they must appear on and compared as that cycle is reached.
module tb_led_sequencer;

    localparam int         LEDS = 6;
    localparam logic [5:0] DARK = 6'h3f;

    logic            clk_in = 1'b0;
    logic            reset;
    logic            tick_in;
    logic [1:0]      mode;
    logic            pause;
    logic [LEDS-1:0] led;

    typedef struct {
        logic [LEDS-1:0] val;
        int              due;
        string           tag;
    } exp_t;

    exp_t sb_q[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    led_sequencer #(.LEDS(LEDS), .ACTIVE_LOW(1'b1)) dut (
        .clk_in  (clk_in),
        .reset   (reset),
        .tick_in (tick_in),
        .mode    (mode),
        .pause   (pause),
        .led     (led)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // Queue a logical pattern to be seen on led after lag edges.
    task automatic push(input string tag, input logic [LEDS-1:0] pat,
                        input int lag);
        exp_t e;
        e.val = pat ^ DARK;
        e.due = cyc + lag;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    always @(posedge clk_in) begin
        #1;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.due < cyc) check({e.tag, "_late"}, 32'(e.due), 32'(cyc));
            else             check(e.tag, 32'(led), 32'(e.val));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic step(input string tag, input logic [LEDS-1:0] pat);
        @(negedge clk_in);
        tick_in = ~tick_in;
        push(tag, pat, 2);
    endtask

    task automatic set_mode(input string tag, input logic [1:0] m,
                            input logic [LEDS-1:0] pat);
        @(negedge clk_in);
        mode = m;
        push(tag, pat, 2);
        idle(2);
    endtask

    logic [LEDS-1:0] walk_tab [6]  = '{6'h02, 6'h04, 6'h08,
                                       6'h10, 6'h20, 6'h01};
    int              bnc_pos  [12] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1, 2};

    initial begin
        reset   = 1'b0;
        tick_in = 1'b0;
        mode    = 2'd0;
        pause   = 1'b0;

        repeat (3) begin
            @(posedge clk_in);
            #1 check("rst_dark", 32'(led), 32'(DARK));
        end
        @(negedge clk_in);
        reset = 1'b1;
        idle(2);
        check("post_rst_dark", 32'(led), 32'(DARK));

        for (int k = 1; k <= 3; k++) begin
            step("count", LEDS'(k));
            @(posedge clk_in);
            #1 check("count_not_early", 32'(led), 32'(LEDS'(k - 1) ^ DARK));
            idle(3);
        end
        for (int k = 4; k <= 64; k++) step("count_wrap", LEDS'(k % 64));
        idle(4);

        set_mode("walk_load", 2'd1, 6'h01);
        for (int k = 0; k < 6; k++) begin
            step("walk", walk_tab[k]);
            idle(1);
        end
        idle(3);

        set_mode("bnc_load", 2'd2, 6'h01);
        for (int k = 0; k < 12; k++) step("bounce", LEDS'(1) << bnc_pos[k]);
        idle(4);

        set_mode("blink_load", 2'd3, 6'h00);
        step("blink_on", 6'h3f);
        step("blink_off", 6'h00);
        idle(1);
        @(negedge clk_in);
        pause = 1'b1;
        repeat (3) begin
            step("paused", 6'h00);
            idle(1);
        end
        @(negedge clk_in);
        pause = 1'b0;
        push("unpause_hold", 6'h00, 2);
        idle(3);
        step("blink_resume", 6'h3f);
        idle(4);

        set_mode("count_load", 2'd0, 6'h00);
        for (int k = 1; k <= 5; k++) step("count5", LEDS'(k));
        idle(3);
        @(negedge clk_in);
        mode    = 2'd1;
        tick_in = ~tick_in;
        push("mode_beats_step", 6'h01, 2);
        idle(2);
        step("after_mode_step", 6'h02);
        idle(4);

        set_mode("bnc_reload", 2'd2, 6'h01);
        for (int k = 0; k < 6; k++) step("bnc_pre_rst", LEDS'(1) << bnc_pos[k]);
        idle(4);
        @(negedge clk_in);
        reset = 1'b0;
        push("midrst_dark", 6'h00, 1);
        push("midrst_hold", 6'h00, 2);
        push("midrst_reload", 6'h01, 3);
        @(negedge clk_in);
        reset = 1'b1;
        idle(4);
        step("midrst_step", 6'h02);

        idle(6);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
